// File: rtl/axis_slave_packet_rx_pkg.sv
// axis_rx_pkg: shared FSM encoding and width helpers for the AXIS packet receiver.
package axis_rx_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int len_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    function automatic logic [127:0] keep_all_ones(input int bytes);
        return (128'd1 << bytes) - 128'd1;
    endfunction
endpackage

// File: rtl/axis_slave_packet_rx_if.sv
// axis_slave_packet_rx_if: AXI4-Stream beat channel between an upstream master and the receiver.
interface axis_slave_packet_rx_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                    S_AXIS_TVALID;
    logic [DATA_WIDTH-1:0]   S_AXIS_TDATA;
    logic [DATA_WIDTH/8-1:0] S_AXIS_TKEEP;
    logic                    S_AXIS_TLAST;
    logic                    S_AXIS_TREADY;

    modport master (
        output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST,
        input  S_AXIS_TREADY
    );

    modport slave (
        input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST,
        output S_AXIS_TREADY
    );
endinterface

// File: rtl/axis_slave_packet_rx_buffer.sv
// axis_rx_buffer: synchronous first-word-fall-through FIFO; pointers carry an extra MSB
// so full and empty can be told apart when the indices match.
module axis_rx_buffer #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count   = wr_q - rd_q;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/axis_slave_packet_rx.sv
// axis_slave_packet_rx: AXIS slave that buffers beats with their last flag, counts beats per
// packet, reports length/error on completion and stalls input until the consumer acks.
module axis_slave_packet_rx
    import axis_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 32,
    parameter int MAX_PKT_BEATS = 64,
    parameter int LEN_W         = len_w(MAX_PKT_BEATS)
) (
    input  logic                   clk,
    input  logic                   reset,
    axis_slave_packet_rx_if.slave  s_axis,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_last,
    output logic                   empty,
    output logic                   full,
    output logic                   pkt_done,
    output logic [LEN_W-1:0]       pkt_len,
    output logic                   pkt_err,
    input  logic                   pkt_ack
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam logic [KW-1:0]    KEEP_ONES = KW'(keep_all_ones(KW));
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_PKT_BEATS);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, nxt_cnt;
    logic             err_q, err_d, done_q, done_d;
    logic             tready, accept, ends;
    logic [AW:0]      buf_count;
    logic [DATA_WIDTH:0] head;

    assign tready  = !reset && state_q != DONE && buf_count != (AW+1)'(DEPTH);
    assign s_axis.S_AXIS_TREADY = tready;
    assign accept  = s_axis.S_AXIS_TVALID && tready;
    assign nxt_cnt = state_q == IDLE ? LEN_W'(1) : cnt_q + 1'b1;
    // Hitting the beat limit ends the packet even without TLAST; the stored beat is marked last.
    assign ends    = s_axis.S_AXIS_TLAST || nxt_cnt == MAX_LEN;

    always_comb begin
        state_d = accept ? (ends ? DONE : RECV) : (state_q == DONE && pkt_ack) ? IDLE : state_q;
        cnt_d   = accept ? nxt_cnt : cnt_q;
        err_d   = accept ? ((state_q != IDLE && err_q) || s_axis.S_AXIS_TKEEP != KEEP_ONES
                            || (nxt_cnt == MAX_LEN && !s_axis.S_AXIS_TLAST)) : err_q;
        done_d  = accept && ends;
        len_d   = done_d ? nxt_cnt : len_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    axis_rx_buffer #(.WIDTH(DATA_WIDTH + 1), .DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (rd_en),
        .din   ({ends, s_axis.S_AXIS_TDATA}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (buf_count)
    );

    assign rd_data  = head[DATA_WIDTH-1:0];
    assign rd_last  = head[DATA_WIDTH];
    assign pkt_done = done_q;
    assign pkt_len  = len_q;
    assign pkt_err  = err_q;
endmodule

// File: tb/tb_axis_slave_packet_rx.sv
// tb_axis_slave_packet_rx: directed stimulus with a queue scoreboard for read-port entries
// and packet completion reports.
module tb_axis_slave_packet_rx;
    localparam int MAX = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic        pkt_ack = 1'b0;
    logic [31:0] rd_data;
    logic        rd_last, empty, full, pkt_done, pkt_err;
    logic [6:0]  pkt_len;

    int checks = 0;
    int failures = 0;
    int mcnt = 0;
    logic merr = 1'b0;
    logic [32:0] rdq [$];
    logic [7:0]  pktq [$];

    axis_slave_packet_rx_if #(.DATA_WIDTH(32)) s_axis ();

    axis_slave_packet_rx #(.DATA_WIDTH(32), .DEPTH(32), .MAX_PKT_BEATS(MAX)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_axis   (s_axis),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .empty    (empty),
        .full     (full),
        .pkt_done (pkt_done),
        .pkt_len  (pkt_len),
        .pkt_err  (pkt_err),
        .pkt_ack  (pkt_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        int nxt;
        logic ends;
        s_axis.S_AXIS_TVALID = 1'b1;
        s_axis.S_AXIS_TDATA  = d;
        s_axis.S_AXIS_TKEEP  = k;
        s_axis.S_AXIS_TLAST  = l;
        @(negedge clk);
        while (!s_axis.S_AXIS_TREADY && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis.S_AXIS_TREADY) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: data %0h never accepted", d);
            s_axis.S_AXIS_TVALID = 1'b0;
            return;
        end
        @(posedge clk);
        nxt  = mcnt + 1;
        ends = l || nxt == MAX;
        rdq.push_back({ends, d});
        merr = (mcnt != 0 && merr) || k != 4'hF || (nxt == MAX && !l);
        if (ends) pktq.push_back({merr, 7'(nxt)});
        mcnt = ends ? 0 : nxt;
        #1;
        s_axis.S_AXIS_TVALID = 1'b0;
    endtask

    task automatic ack();
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        rd_en = 1'b1;
        while (!empty && n < 100) begin
            tick();
            n++;
        end
        rd_en = 1'b0;
        check("drain_empty", empty, 1);
    endtask

    // Scoreboard monitor: every pop and every completion pulse must match the next expectation.
    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            if (rdq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got %0h expected no entry", {rd_last, rd_data});
            end else begin
                check("rd_entry", {rd_last, rd_data}, rdq.pop_front());
            end
        end
        if (pkt_done) begin
            if (pktq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pkt_unexpected: got len %0d err %0d expected no report", pkt_len, pkt_err);
            end else begin
                check("pkt_report", {pkt_err, pkt_len}, pktq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.S_AXIS_TVALID = 1'b0;
        s_axis.S_AXIS_TDATA  = '0;
        s_axis.S_AXIS_TKEEP  = '0;
        s_axis.S_AXIS_TLAST  = 1'b0;
        repeat (3) tick();
        check("rst_tready", s_axis.S_AXIS_TREADY, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_done", pkt_done, 0);
        check("rst_len", pkt_len, 0);
        check("rst_err", pkt_err, 0);
        reset = 1'b0;
        #1;
        check("rst_tready_after", s_axis.S_AXIS_TREADY, 1);
        tick();

        // Basic 17-beat packet, no pops until after ack.
        for (int i = 5; i <= 20; i++) send(32'(i), 4'hF, 1'b0);
        send(32'hFFFF_FFFF, 4'hF, 1'b1);
        check("basic_done", pkt_done, 1);
        check("basic_len", pkt_len, 17);
        check("basic_tready", s_axis.S_AXIS_TREADY, 0);
        tick();
        check("basic_done_pulse", pkt_done, 0);
        tick();
        check("basic_hold", s_axis.S_AXIS_TREADY, 0);
        ack();
        check("basic_ack_tready", s_axis.S_AXIS_TREADY, 1);
        drain_all();

        // Backpressure: 40-beat packet against a 32-entry buffer.
        for (int i = 0; i < 32; i++) send(32'hA000 + 32'(i), 4'hF, 1'b0);
        check("bp_full", full, 1);
        check("bp_tready", s_axis.S_AXIS_TREADY, 0);
        repeat (2) tick();
        check("bp_hold", s_axis.S_AXIS_TREADY, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("bp_pop_tready", s_axis.S_AXIS_TREADY, 1);
        check("bp_pop_full", full, 0);
        rd_en = 1'b1;
        for (int i = 32; i < 40; i++) send(32'hA000 + 32'(i), 4'hF, i == 39);
        check("bp_done", pkt_done, 1);
        ack();
        drain_all();

        // Truncation at MAX beats while the consumer drains continuously.
        rd_en = 1'b1;
        for (int i = 0; i < MAX; i++) send(32'hB000 + 32'(i), 4'hF, 1'b0);
        check("trunc_done", pkt_done, 1);
        check("trunc_len", pkt_len, MAX);
        check("trunc_err", pkt_err, 1);
        ack();
        send(32'hB040, 4'hF, 1'b0);
        send(32'hB041, 4'hF, 1'b1);
        check("trunc_next_len", pkt_len, 2);
        check("trunc_next_err", pkt_err, 0);
        ack();
        drain_all();

        // Illegal TKEEP on beat 2.
        send(32'hC001, 4'hF, 1'b0);
        send(32'hC002, 4'b0111, 1'b0);
        send(32'hC003, 4'hF, 1'b0);
        send(32'hC004, 4'hF, 1'b1);
        check("keep_len", pkt_len, 4);
        check("keep_err", pkt_err, 1);
        ack();
        drain_all();

        // Ack in IDLE and RECV is ignored.
        ack();
        check("ack_idle_state", dut.state_q, 0);
        check("ack_idle_tready", s_axis.S_AXIS_TREADY, 1);
        send(32'hD001, 4'hF, 1'b0);
        send(32'hD002, 4'hF, 1'b0);
        ack();
        check("ack_recv_state", dut.state_q, 1);
        send(32'hD003, 4'hF, 1'b1);
        ack();
        drain_all();

        // Read while empty, then push+pop at count 5.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rd_empty_empty", empty, 1);
        check("rd_empty_count", dut.u_buf.count, 0);
        for (int i = 0; i < 5; i++) send(32'hE000 + 32'(i), 4'hF, 1'b0);
        check("pp_count_before", dut.u_buf.count, 5);
        rd_en = 1'b1;
        send(32'hE005, 4'hF, 1'b0);
        rd_en = 1'b0;
        check("pp_count_after", dut.u_buf.count, 5);
        send(32'hE006, 4'hF, 1'b1);
        ack();
        drain_all();

        // Reset in the middle of a 10-beat packet.
        for (int i = 0; i < 5; i++) send(32'hF000 + 32'(i), 4'hF, 1'b0);
        reset = 1'b1;
        tick();
        check("mid_rst_empty", empty, 1);
        check("mid_rst_state", dut.state_q, 0);
        check("mid_rst_len", pkt_len, 0);
        rdq.delete();
        mcnt = 0;
        merr = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_tready", s_axis.S_AXIS_TREADY, 1);
        send(32'h1001, 4'hF, 1'b0);
        send(32'h1002, 4'hF, 1'b0);
        send(32'h1003, 4'hF, 1'b1);
        check("mid_rst_next_len", pkt_len, 3);
        ack();
        drain_all();

        tick();
        check("left_rd", rdq.size(), 0);
        check("left_pkt", pktq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
